// File: rtl/sccb_responder_if.sv
// Parallel register port of the SCCB responder: write strobe/address/data,
// read pointer with its returned value, and bus-busy status.
interface sccb_responder_if;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;

    modport slave (
        output wr_en, wr_addr, wr_data, rd_addr, busy,
        input  rd_data
    );

    modport master (
        input  wr_en, wr_addr, wr_data, rd_addr, busy,
        output rd_data
    );
endinterface

// File: rtl/sccb_responder.sv
// SCCB responder: oversamples sioc/siod on clk, decodes start/stop/ID/sub-address/
// data phases and presents writes and reads on a parallel register port.
module sccb_responder #(
    parameter logic [7:0] SID         = 8'h60,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sioc,
    inout  wire              siod,
    sccb_responder_if.slave  rif
);

    typedef enum logic [3:0] {
        IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] sioc_sync_q, sioc_sync_d;
    logic [SYNC_STAGES-1:0] siod_sync_q, siod_sync_d;
    logic                   sioc_prev_q, sioc_prev_d;
    logic                   siod_prev_q, siod_prev_d;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        sda_low_q, sda_low_d;
    logic        busy_q, busy_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;

    logic        sc_s, sd_s;
    logic        rise, fall, start_ev, stop_ev;
    logic [7:0]  byte_in;

    // Synchroniser plus one edge-detect stage; left unreset so a reset never fabricates bus events
    always_comb begin
        sioc_sync_d = {sioc_sync_q[SYNC_STAGES-2:0], sioc};
        siod_sync_d = {siod_sync_q[SYNC_STAGES-2:0], siod};
        sioc_prev_d = sioc_sync_q[SYNC_STAGES-1];
        siod_prev_d = siod_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        sioc_sync_q <= sioc_sync_d;
        siod_sync_q <= siod_sync_d;
        sioc_prev_q <= sioc_prev_d;
        siod_prev_q <= siod_prev_d;
    end

    assign sc_s     = sioc_sync_q[SYNC_STAGES-1];
    assign sd_s     = siod_sync_q[SYNC_STAGES-1];
    assign rise     = sc_s & ~sioc_prev_q;
    assign fall     = ~sc_s & sioc_prev_q;
    assign start_ev = sc_s & sioc_prev_q & siod_prev_q & ~sd_s;
    assign stop_ev  = sc_s & sioc_prev_q & ~siod_prev_q & sd_s;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        sda_low_d = sda_low_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        byte_in   = {sh_q[6:0], sd_s};

        if (start_ev) begin
            state_d   = ID;
            cnt_d     = 4'd0;
            sda_low_d = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_ev) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ID, ADDR, WDATA: begin
                    if (rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (state_q == ID) begin
                                if (byte_in[7:1] == SID[7:1]) begin
                                    state_d = ID_ACK;
                                    rw_d    = byte_in[0];
                                end else begin
                                    state_d = IGNORE;
                                end
                            end else if (state_q == ADDR) begin
                                state_d = ADDR_ACK;
                                ptr_d   = byte_in;
                            end else begin
                                state_d   = WDATA_ACK;
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = byte_in;
                            end
                        end
                    end
                end
                // cnt: 0 = waiting for bit-8 fall, 1 = driving, waiting bit-9 rise, 2 = waiting bit-9 fall
                ID_ACK, ADDR_ACK, WDATA_ACK: begin
                    if (fall && cnt_q == 4'd0) begin
                        sda_low_d = 1'b1;
                        cnt_d     = 4'd1;
                    end else if (rise && cnt_q == 4'd1) begin
                        cnt_d = 4'd2;
                    end else if (fall && cnt_q == 4'd2) begin
                        sda_low_d = 1'b0;
                        cnt_d     = 4'd0;
                        if (state_q == ID_ACK) begin
                            if (rw_q) begin
                                state_d   = RDATA;
                                sh_d      = rif.rd_data;
                                sda_low_d = ~rif.rd_data[7];
                            end else begin
                                state_d = ADDR;
                            end
                        end else if (state_q == ADDR_ACK) begin
                            state_d = WDATA;
                        end else begin
                            state_d = WDATA;
                            ptr_d   = ptr_q + 8'd1;
                        end
                    end
                end
                RDATA: begin
                    if (rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            cnt_d     = 4'd0;
                            state_d   = RD_NA;
                        end else begin
                            sda_low_d = ~sh_q[6];
                            sh_d      = {sh_q[6:0], 1'b0};
                        end
                    end
                end
                RD_NA: begin
                    if (rise && cnt_q == 4'd0) begin
                        if (sd_s) begin
                            state_d = IGNORE;
                        end else begin
                            ptr_d = ptr_q + 8'd1;
                            cnt_d = 4'd1;
                        end
                    end else if (fall && cnt_q == 4'd1) begin
                        state_d   = RDATA;
                        cnt_d     = 4'd0;
                        sh_d      = rif.rd_data;
                        sda_low_d = ~rif.rd_data[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            ptr_q     <= 8'd0;
            rw_q      <= 1'b0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            sda_low_q <= sda_low_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign siod        = sda_low_q ? 1'b0 : 1'bz;
    assign rif.wr_en   = wr_en_q;
    assign rif.wr_addr = wr_addr_q;
    assign rif.wr_data = wr_data_q;
    assign rif.rd_addr = ptr_q;
    assign rif.busy    = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: bit-level SCCB master model, register memory behind
// rd_addr, and queues holding the writes and read bytes the master expects.
module tb_sccb_responder;

    logic clk = 1'b0;
    logic reset;
    logic sioc;
    logic m_low;
    wire  siod;

    logic [7:0]  mem [256];
    logic [15:0] wq[$];
    logic [7:0]  rq[$];
    int          checks = 0;
    int          errors = 0;
    int          q_clks = 20;
    int          dut_low_cnt = 0;
    int          wr_cnt = 0;
    logic        wr_en_prev = 1'b0;

    sccb_responder_if rif();

    assign siod = m_low ? 1'b0 : 1'bz;
    pullup (siod);
    assign rif.rd_data = mem[rif.rd_addr];

    sccb_responder #(.SID(8'h60), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .sioc  (sioc),
        .siod  (siod),
        .rif   (rif)
    );

    always #10 clk = ~clk;

    // Write scoreboard: each wr_en pulse pops the oldest expected (addr,data)
    always @(negedge clk) begin
        if (siod === 1'b0 && !m_low) dut_low_cnt++;
        if (rif.wr_en === 1'b1) begin
            wr_cnt++;
            checks++;
            if (wr_en_prev === 1'b1) begin
                errors++;
                $display("FAIL wr_en_width: wr_en high %0d clks, expected 1", 2);
            end else if (wq.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: addr=%h data=%h, expected no write", rif.wr_addr, rif.wr_data);
            end else begin
                logic [15:0] exp;
                exp = wq.pop_front();
                if ({rif.wr_addr, rif.wr_data} !== exp)  begin
                    errors++;
                    $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                             rif.wr_addr, rif.wr_data, exp[15:8], exp[7:0]);
                end
            end
        end
        wr_en_prev <= rif.wr_en;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation still running after %0d clks, expected done", 80000);
        $fatal(1, "timeout");
    end

    task automatic wait_q(input int n);
        repeat (n * q_clks) @(negedge clk);
    endtask

    task automatic bus_start();
        m_low = 1'b0; sioc = 1'b1; wait_q(2);
        m_low = 1'b1; wait_q(2);
        sioc = 1'b0;
    endtask

    task automatic bus_stop();
        wait_q(1); m_low = 1'b1;
        wait_q(1); sioc = 1'b1;
        wait_q(2); m_low = 1'b0;
        wait_q(2);
    endtask

    // Entry and exit right after a sioc fall; data set mid-low, sampled mid-high
    task automatic clock_bit(input logic b, output logic s);
        wait_q(1); m_low = !b;
        wait_q(1); sioc = 1'b1;
        wait_q(1); s = siod;
        wait_q(1); sioc = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            v[i] = s;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; sioc = 1'b1; m_low = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (rif.wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en: got %b expected 0", rif.wr_en); end
        checks++; if (rif.wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr: got %h expected 00", rif.wr_addr); end
        checks++; if (rif.wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data: got %h expected 00", rif.wr_data); end
        checks++; if (rif.rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr: got %h expected 00", rif.rd_addr); end
        checks++; if (rif.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", rif.busy); end
        checks++; if (siod !== 1'b1)         begin errors++; $display("FAIL reset_siod: got %b expected 1", siod); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_write();
        logic a;
        q_clks = 125;
        bus_start();
        wait_q(1);
        checks++; if (rif.busy !== 1'b1) begin errors++; $display("FAIL bw_busy_start: got %b expected 1", rif.busy); end
        write_byte(8'h60, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL bw_id_ack: got %b expected 0", a); end
        write_byte(8'h12, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL bw_addr_ack: got %b expected 0", a); end
        wq.push_back({8'h12, 8'h80});
        write_byte(8'h80, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL bw_data_ack: got %b expected 0", a); end
        bus_stop();
        checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL bw_busy_stop: got %b expected 0", rif.busy); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL bw_pending: %0d writes missing, expected 0", wq.size()); end
        q_clks = 20;
    endtask

    task automatic test_wrong_id();
        logic a;
        int   w0;
        w0 = wr_cnt;
        dut_low_cnt = 0;
        bus_start();
        write_byte(8'h42, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wid_id_ack: got %b expected 1", a); end
        write_byte(8'h10, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL wid_addr_ack: got %b expected 1", a); end
        write_byte(8'h55, a);
        bus_stop();
        checks++; if (dut_low_cnt != 0) begin errors++; $display("FAIL wid_drive: siod pulled low %0d clks, expected 0", dut_low_cnt); end
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL wid_wr: %0d writes, expected 0", wr_cnt - w0); end
        checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL wid_busy: got %b expected 0", rif.busy); end
    endtask

    task automatic test_wrap();
        logic a;
        bus_start();
        write_byte(8'h60, a);
        write_byte(8'hFF, a);
        wq.push_back({8'hFF, 8'hAA});
        write_byte(8'hAA, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack1: got %b expected 0", a); end
        wq.push_back({8'h00, 8'hBB});
        write_byte(8'hBB, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL wrap_ack2: got %b expected 0", a); end
        bus_stop();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL wrap_pending: %0d writes missing, expected 0", wq.size()); end
        checks++; if (rif.rd_addr !== 8'h01) begin errors++; $display("FAIL wrap_ptr: got %h expected 01", rif.rd_addr); end
    endtask

    task automatic test_read_na();
        logic       a, s, any_low;
        logic [7:0] b, exp;
        bus_start();
        write_byte(8'h60, a);
        write_byte(8'h0A, a);
        bus_stop();
        checks++; if (rif.rd_addr !== 8'h0A) begin errors++; $display("FAIL rna_ptr: got %h expected 0a", rif.rd_addr); end
        mem[8'h0A] = 8'hC5;
        rq.push_back(8'hC5);
        bus_start();
        write_byte(8'h61, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rna_id_ack: got %b expected 0", a); end
        read_byte(b);
        exp = rq.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL rna_byte: got %h expected %h", b, exp); end
        clock_bit(1'b1, s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL rna_na_bit: got %b expected 1", s); end
        any_low = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clock_bit(1'b1, s);
            if (s !== 1'b1) any_low = 1'b1;
        end
        checks++; if (any_low !== 1'b0) begin errors++; $display("FAIL rna_after_na: siod low=%b expected 0", any_low); end
        bus_stop();
    endtask

    task automatic test_read_ack();
        logic       a, s;
        logic [7:0] b, exp;
        bus_start();
        write_byte(8'h60, a);
        write_byte(8'h30, a);
        bus_stop();
        mem[8'h30] = 8'h01;
        mem[8'h31] = 8'h02;
        rq.push_back(8'h01);
        rq.push_back(8'h02);
        bus_start();
        write_byte(8'h61, a);
        read_byte(b);
        exp = rq.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL rack_byte1: got %h expected %h", b, exp); end
        clock_bit(1'b0, s);
        read_byte(b);
        exp = rq.pop_front();
        checks++; if (b !== exp) begin errors++; $display("FAIL rack_byte2: got %h expected %h", b, exp); end
        clock_bit(1'b1, s);
        bus_stop();
        checks++; if (rif.rd_addr !== 8'h31) begin errors++; $display("FAIL rack_ptr: got %h expected 31", rif.rd_addr); end
    endtask

    task automatic test_reset_mid();
        logic       a, s;
        logic [7:0] v;
        // Reset while the ID ack is being driven
        bus_start();
        v = 8'h60;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
        m_low = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (siod !== 1'b0) begin errors++; $display("FAIL rmid_ack_drive: got %b expected 0", siod); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (siod !== 1'b1) begin errors++; $display("FAIL rmid_release: got %b expected 1", siod); end
        checks++; if (rif.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy1: got %b expected 0", rif.busy); end
        reset = 1'b0;
        clock_bit(1'b1, s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL rmid_bit9: got %b expected 1", s); end
        bus_stop();
        // Reset in the middle of the sub-address byte
        bus_start();
        write_byte(8'h60, a);
        v = 8'h12;
        for (int i = 7; i >= 4; i--) clock_bit(v[i], s);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        checks++; if (rif.busy !== 1'b0)     begin errors++; $display("FAIL rmid_busy2: got %b expected 0", rif.busy); end
        checks++; if (rif.rd_addr !== 8'h00) begin errors++; $display("FAIL rmid_rd_addr: got %h expected 00", rif.rd_addr); end
        checks++; if (rif.wr_en !== 1'b0)    begin errors++; $display("FAIL rmid_wr_en: got %b expected 0", rif.wr_en); end
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL rmid_addr_ack: got %b expected 1", s); end
        write_byte(8'h77, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rmid_data_ack: got %b expected 1", a); end
        bus_stop();
        // Next complete write is accepted normally
        bus_start();
        write_byte(8'h60, a);
        write_byte(8'h21, a);
        wq.push_back({8'h21, 8'h5A});
        write_byte(8'h5A, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rmid_post_ack: got %b expected 0", a); end
        bus_stop();
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rmid_pending: %0d writes missing, expected 0", wq.size()); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        sioc  = 1'b1;
        m_low = 1'b0;
        reset = 1'b1;
        test_reset();
        test_basic_write();
        test_wrong_id();
        test_wrap();
        test_read_na();
        test_read_ack();
        test_reset_mid();
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- SCCB slave (responder) that answers the register-write transactions our camera-configuration SCCB master issues, plus SCCB reads.
- Used as a camera model on the bench and as an on-chip configuration target behind the same two-wire bus.
- Samples sioc/siod with the fast system clock and decodes start/stop, ID, sub-address and data phases.
- Presents register writes and reads on a simple parallel register port.

Parameters:
- SID, 8'h60, 7-bit device ID in bits [7:1]; bit0 of the received ID byte selects write (0) or read (1).
- SYNC_STAGES, 2, synchroniser depth on sioc and siod (minimum 2).

Ports:
- clk  input  1  system clock (50 MHz); all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- sioc  input  1  SCCB clock from the master.
- siod  inout  1  SCCB data; open-drain: driven 0 or left high-Z, never driven 1.
- wr_en  output  1  one-clk pulse; a register write is valid this cycle.
- wr_addr  output  8  register address for the write.
- wr_data  output  8  register data for the write.
- rd_addr  output  8  current sub-address pointer.
- rd_data  input  8  register value at rd_addr; must be valid combinationally or within 1 clk.
- busy  output  1  high from a detected start until the next stop.

Behaviour:
- Inputs: sioc and siod pass through SYNC_STAGES flops, then one extra flop for edge detection.
- Bus events, all on synchronised signals:
  - rise = sioc 0→1; fall = sioc 1→0.
  - start = siod 1→0 while sioc=1.
  - stop = siod 0→1 while sioc=1.
- Bit timing:
  - Received bits are sampled on rise, MSB first.
  - The responder changes its siod drive only on fall.
- FSM states: IDLE, ID, ID_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, IGNORE.
- Start from any state, including a repeated start: bit counter cleared, siod released, → ID.
- Stop from any state: siod released, → IDLE.
- ID state:
  - After 8 bits, if byte[7:1] == SID[7:1] → ID_ACK.
  - Otherwise → IGNORE; no ack is driven and nothing is output until stop or start.
- ACK handling:
  - In every *_ACK state the responder drives siod=0 from the fall after bit 8 to the fall after bit 9.
  - Bit-9 duration is counted by rise.
- Transitions after each ACK:
  - ID_ACK → ADDR if the ID byte was a write.
  - ID_ACK → RDATA if it was a read; in that case rd_data is loaded into the shift register at the bit-9 fall and bit 7 is driven on that same fall.
  - ADDR_ACK: the pointer is loaded with the received byte; → WDATA.
  - WDATA: after 8 bits, wr_en pulses for exactly one clk with wr_addr=pointer and wr_data=byte; → WDATA_ACK.
  - WDATA_ACK → WDATA; the pointer increments by 1 (8-bit wrap, 8'hFF→8'h00) at the end of the ACK.
- RDATA / RD_NA:
  - RDATA drives the bits: a 0 bit drives siod low, a 1 bit releases it.
  - siod is released at the fall after bit 8; → RD_NA.
  - RD_NA samples the master bit at the bit-9 rise.
  - If the master bit = 1 (NA) → IGNORE.
  - If the master bit = 0 (ACK): the pointer increments, rd_data is reloaded, and the FSM → RDATA.
- Pointer: persists across transactions, so a write-ID + address followed by stop then read-ID reads that address.
- busy: set on start, cleared on stop.
- Reset values:
  - State IDLE, siod high-Z.
  - wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, busy=0.
  - Shift register and bit counter = 0.
- Reset mid-transaction: abort immediately and apply the reset values; the bus is ignored until the next start.
- Simultaneous events:
  - Start and stop cannot coincide; treat start as having priority.
  - Edges with sioc low are data transitions only and are never decoded as events.

Test Plan:
- 3-phase write, ID 8'h60, addr 8'h12, data 8'h80 (≈100 kHz sioc) → ack low on all three 9th bits; one wr_en pulse with wr_addr=8'h12, wr_data=8'h80; busy drops after stop.
- ID 8'h42 write → siod never driven low; no wr_en; FSM back to IDLE after stop.
- Write 8'h60, addr 8'hFF, data 8'hAA, 8'hBB → writes (FF,AA) then (00,BB); pointer wrap confirmed.
- Write-ID 8'h60 + addr 8'h0A, stop, then read-ID 8'h61 with rd_data=8'hC5 → siod carries 11000101; master NA → no further drive.
- Read with master ACK after byte 1, rd_data=8'h01 then 8'h02 → second byte read from rd_addr=pointer+1; bytes 8'h01, 8'h02 returned.
- Reset asserted mid-ADDR phase → siod released within 1 clk, all outputs at reset values; next full write is accepted normally.
